// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream loader that packs words into the
// instruction memory and releases the core once the image checksum matches.
module imem_boot_loader #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MAX_WORDS  = 256,
  parameter logic [7:0]            SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_err,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state, state_nx;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
  logic [7:0]  chk;
  logic        take;
  logic [15:0] n_hdr;

  assign take  = in_valid & in_ready;
  assign n_hdr = {in_data, len_lo};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b1;
    load_done  = 1'b0;
    load_err   = 1'b0;
    core_reset = 1'b1;
    case (state)
      IDLE: if (take && in_data == SYNC_BYTE) state_nx = LEN0;
      LEN0: if (take) state_nx = LEN1;
      LEN1: if (take) state_nx = (n_hdr == 16'd0 || {1'b0, n_hdr} > MAX_W) ? ERR : DATA;
      DATA: if (take && byte_idx == 2'd3 && words_loaded == len - 16'd1) state_nx = CHK;
      CHK:  if (take) state_nx = (in_data == chk) ? DONE : ERR;
      DONE: begin
        in_ready   = 1'b0;
        load_done  = 1'b1;
        core_reset = 1'b0;
      end
      ERR: begin
        in_ready = 1'b0;
        load_err = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // words_loaded doubles as the index of the word currently being assembled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_lo       <= '0;
      len          <= '0;
      byte_idx     <= '0;
      asm_q        <= '0;
      chk          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (take) begin
        case (state)
          LEN0: len_lo <= in_data;
          LEN1: begin
            len          <= n_hdr;
            byte_idx     <= '0;
            chk          <= '0;
            words_loaded <= '0;
          end
          DATA: begin
            chk      <= chk ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_q[7:0]   <= in_data;
              2'd1: asm_q[15:8]  <= in_data;
              2'd2: asm_q[23:16] <= in_data;
              default: begin
                imem_we      <= 1'b1;
                imem_addr    <= BASE_ADDR + ADDR_WIDTH'({words_loaded, 2'b00});
                imem_wdata   <= {in_data, asm_q};
                words_loaded <= words_loaded + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader; frames are
// built from random word lists and the expected writes/status follow from that list.
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready0, imem_we0, core_reset0, load_done0, load_err0;
  logic [31:0] imem_addr0, imem_wdata0;
  logic [15:0] words0;
  logic        in_ready1, imem_we1, core_reset1, load_done1, load_err1;
  logic [31:0] imem_addr1, imem_wdata1;
  logic [15:0] words1;

  always #5 clk = ~clk;

  imem_boot_loader dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .imem_we(imem_we0), .imem_addr(imem_addr0),
    .imem_wdata(imem_wdata0), .core_reset(core_reset0), .load_done(load_done0),
    .load_err(load_err0), .words_loaded(words0)
  );

  imem_boot_loader #(.BASE_ADDR(32'h100)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .imem_we(imem_we1), .imem_addr(imem_addr1),
    .imem_wdata(imem_wdata1), .core_reset(core_reset1), .load_done(load_done1),
    .load_err(load_err1), .words_loaded(words1)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] wq0[$], wq1[$];
  logic [63:0] xw[$];
  logic [7:0]  fb[$];
  bit          fw[$];

  always @(negedge clk) begin
    if (imem_we0) wq0.push_back({imem_addr0, imem_wdata0});
    if (imem_we1) wq1.push_back({imem_addr1, imem_wdata1});
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame = sync, count lo/hi, then (only for a legal count) words LE and XOR checksum.
  task automatic build_frame(int n, bit bad);
    logic [31:0] w;
    logic [7:0]  c;
    logic [15:0] n16;
    c = 8'h00;
    n16 = 16'(n);
    fb.delete(); fw.delete(); xw.delete();
    fb.push_back(8'hA5); fb.push_back(n16[7:0]); fb.push_back(n16[15:8]);
    repeat (3) fw.push_back(1'b0);
    if (n >= 1 && n <= 256) begin
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        for (int b = 0; b < 4; b++) begin
          fb.push_back(w[8*b +: 8]);
          fw.push_back(b == 3);
          c ^= w[8*b +: 8];
        end
        xw.push_back({32'(4 * i), w});
      end
      fb.push_back(c ^ {7'd0, bad});
      fw.push_back(1'b0);
    end
  endtask

  task automatic send_range(int lo, int hi, int max_gap);
    for (int i = lo; i < hi; i++) begin
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      in_valid = 1'b1;
      in_data  = fb[i];
      check("in_ready0_frame", in_ready0, 1);
      check("in_ready1_frame", in_ready1, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("we0_after_byte", imem_we0, fw[i]);
      check("we1_after_byte", imem_we1, fw[i]);
    end
  endtask

  task automatic check_end(bit ok, int nw);
    repeat (2) @(negedge clk);
    check("load_done0", load_done0, ok);
    check("load_err0", load_err0, !ok);
    check("core_reset0", core_reset0, !ok);
    check("in_ready0_end", in_ready0, 0);
    check("words0", words0, nw);
    check("load_done1", load_done1, ok);
    check("load_err1", load_err1, !ok);
    check("words1", words1, nw);
    check("nwrites0", wq0.size(), xw.size());
    check("nwrites1", wq1.size(), xw.size());
    for (int i = 0; i < xw.size(); i++) begin
      if (i < wq0.size()) check("write0", wq0[i], xw[i]);
      if (i < wq1.size()) check("write1", wq1[i], {xw[i][63:32] + 32'h100, xw[i][31:0]});
    end
  endtask

  task automatic hold(bit ok);
    int s0, s1;
    s0 = wq0.size();
    s1 = wq1.size();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = (i == 0) ? 8'hA5 : 8'($urandom);
      check("in_ready0_hold", in_ready0, 0);
      check("in_ready1_hold", in_ready1, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_writes0", wq0.size(), s0);
    check("hold_writes1", wq1.size(), s1);
    check("hold_done0", load_done0, ok);
    check("hold_err0", load_err0, !ok);
    check("hold_core_reset0", core_reset0, !ok);
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready0", in_ready0, 1);
    check("rst_core_reset0", core_reset0, 1);
    check("rst_done0", load_done0, 0);
    check("rst_err0", load_err0, 0);
    check("rst_we0", imem_we0, 0);
    check("rst_addr0", imem_addr0, 0);
    check("rst_wdata0", imem_wdata0, 0);
    check("rst_words0", words0, 0);
    check("rst_in_ready1", in_ready1, 1);
    check("rst_addr1", imem_addr1, 0);
    check("rst_words1", words1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    wq0.delete();
    wq1.delete();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);

    // Single word 0x13 at address 0.
    fb = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    fw = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    xw = '{{32'h0, 32'h13}};
    send_range(0, fb.size(), 0);
    check_end(1'b1, 1);
    hold(1'b1);

    // Garbage ahead of a 2-word frame, with gaps between bytes.
    do_reset();
    build_frame(2, 1'b0);
    fb.push_front(8'h5A); fb.push_front(8'hFF); fb.push_front(8'h00);
    repeat (3) fw.push_front(1'b0);
    send_range(0, fb.size(), 3);
    check_end(1'b1, 2);

    // Illegal counts: zero and MAX_WORDS+1.
    do_reset();
    build_frame(0, 1'b0);
    send_range(0, fb.size(), 1);
    check_end(1'b0, 0);
    hold(1'b0);
    do_reset();
    build_frame(257, 1'b0);
    send_range(0, fb.size(), 1);
    check_end(1'b0, 0);

    // Corrupted checksum: word still written, then error.
    do_reset();
    build_frame(1, 1'b1);
    send_range(0, fb.size(), 2);
    check_end(1'b0, 1);

    // Reset two bytes into word 1 of a 3-word frame.
    do_reset();
    build_frame(3, 1'b0);
    send_range(0, 9, 1);
    check("abort_pre_writes0", wq0.size(), 1);
    do_reset();
    repeat (3) @(negedge clk);
    check("abort_writes0", wq0.size(), 0);
    check("abort_writes1", wq1.size(), 0);

    // Reset right after the byte that completes a word: the pending write is dropped.
    build_frame(2, 1'b0);
    send_range(0, 6, 0);
    in_valid = 1'b1;
    in_data  = fb[6];
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("pend_we0", imem_we0, 0);
    check("pend_words0", words0, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("pend_writes0", wq0.size(), 0);
    check("pend_in_ready0", in_ready0, 1);

    // Fresh frames after reset, randomized sizes, gaps and checksum faults.
    for (int k = 0; k < 6; k++) begin
      int  n;
      bit  bad;
      do_reset();
      n   = $urandom_range(6, 1);
      bad = ($urandom_range(3, 0) == 0);
      build_frame(n, bad);
      send_range(0, fb.size(), 2);
      check_end(!bad, n);
    end

    // Largest legal image.
    do_reset();
    build_frame(256, 1'b0);
    send_range(0, fb.size(), 0);
    check_end(1'b1, 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
